// File: rtl/pattern_scan_arbiter_if.sv
// rtl/pattern_scan_arbiter_if.sv - requester/result bundle for the shared pattern scanner
//
// Requester side : req0/data0, req1/data1 (level request + parallel word)
// Result side    : busy, gnt_id, ser_bit, match, done, count
// master modport : used by the requesters (drives req/data, observes results)
// slave modport  : used by pattern_scan_arbiter
interface pattern_scan_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             busy;
  logic             gnt_id;
  logic             ser_bit;
  logic             match;
  logic             done;
  logic [CNT_W-1:0] count;

  modport master (
    output req0, data0, req1, data1,
    input  busy, gnt_id, ser_bit, match, done, count
  );

  modport slave (
    input  req0, data0, req1, data1,
    output busy, gnt_id, ser_bit, match, done, count
  );
endinterface

// File: rtl/pattern_scan_arbiter.sv
// rtl/pattern_scan_arbiter.sv - round-robin shared serial "1010" Mealy detector
//
// clk   : rising-edge clock
// reset : asynchronous active-low reset
// bus   : slave side of pattern_scan_arbiter_if
//         in  req0/data0, req1/data1
//         out busy, gnt_id, ser_bit, match, done, count
module pattern_scan_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pattern_scan_arbiter_if.slave bus
);

  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {D_START, D_S1, D_S10, D_S101} det_t;

  state_t           state, state_nxt;
  det_t             det, det_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic [CNT_W-1:0] count_q;
  logic             gnt_q;
  logic             last_q;   // requester served by the most recent accept
  logic             any_req;
  logic             sel;
  logic             last_bit;
  logic             ser;
  logic             det_match;

  assign ser      = shreg[WIDTH-1];
  assign any_req  = bus.req0 | bus.req1;
  assign last_bit = (bitcnt == BW'(WIDTH - 1));

  // On a tie the requester not served last wins; otherwise the lone
  // requester wins (sel is don't-care when neither is asking).
  always_comb begin
    sel = 1'b0;
    if (bus.req0 && bus.req1) begin
      sel = ~last_q;
    end else begin
      sel = ~bus.req0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Overlapping detector: after a match the trailing "10" is kept (S10).
  always_comb begin
    det_nxt   = D_START;
    det_match = 1'b0;
    case (det)
      D_START: det_nxt = ser ? D_S1 : D_START;
      D_S1:    det_nxt = ser ? D_S1 : D_S10;
      D_S10:   det_nxt = ser ? D_S101 : D_START;
      D_S101: begin
        if (ser) begin
          det_nxt = D_S1;
        end else begin
          det_nxt   = D_S10;
          det_match = 1'b1;
        end
      end
      default: det_nxt = D_START;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bitcnt  <= '0;
      count_q <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      det     <= D_START;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            shreg   <= sel ? bus.data1 : bus.data0;
            gnt_q   <= sel;
            last_q  <= sel;
            bitcnt  <= '0;
            count_q <= '0;
            det     <= D_START;
          end
        end
        SHIFT: begin
          det    <= det_nxt;
          shreg  <= {shreg[WIDTH-2:0], 1'b0};
          bitcnt <= bitcnt + BW'(1);
          if (det_match) count_q <= count_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.gnt_id  = gnt_q;
  assign bus.ser_bit = ser;
  assign bus.match   = det_match && (state == SHIFT);
  assign bus.count   = count_q;

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// tb/tb_pattern_scan_arbiter.sv - scoreboard bench for pattern_scan_arbiter
module tb_pattern_scan_arbiter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef struct {
    logic             gnt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pattern_scan_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  pattern_scan_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   idx = 0;
  logic [WIDTH-1:0] seen_mask = '0;
  logic prev_busy = 1'b0;
  exp_t sb[$];
  int   acc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Position i (0-based shift order) matches when the four bits ending there read 1010.
  function automatic logic [WIDTH-1:0] ref_mask(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 3; i < WIDTH; i++) begin
      if ({w[WIDTH-1-i+3], w[WIDTH-1-i+2], w[WIDTH-1-i+1], w[WIDTH-1-i]} == 4'b1010)
        m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic exp_t mk_exp(input logic g, input logic [WIDTH-1:0] w);
    exp_t e;
    e.gnt  = g;
    e.mask = ref_mask(w);
    e.cnt  = CNT_W'($countones(e.mask));
    return e;
  endfunction

  // One cycle; observes the DUT at the falling edge and retires scoreboard entries on done.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!reset) begin
      idx = 0;
      seen_mask = '0;
    end else begin
      if (bus.busy && !prev_busy) acc_q.push_back(cyc);
      if (bus.done) begin
        chk("spurious_done", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("done_gnt_id", 32'(bus.gnt_id), 32'(e.gnt));
          chk("done_count", 32'(bus.count), 32'(e.cnt));
          chk("match_positions", 32'(seen_mask), 32'(e.mask));
          chk("shift_cycles", 32'(idx), WIDTH);
        end
        idx = 0;
        seen_mask = '0;
      end else if (bus.busy) begin
        if (bus.match && idx < WIDTH) seen_mask[idx] = 1'b1;
        idx++;
      end else begin
        chk("match_idle", 32'(bus.match), 32'd0);
      end
    end
    prev_busy = bus.busy;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!bus.busy && n < 30) begin tick(); n++; end
    chk("accept_timeout", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 60) begin tick(); n++; end
    chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic run_job(input logic id, input logic [WIDTH-1:0] w);
    exp_t e;
    int   lat;
    e = mk_exp(id, w);
    if (id) begin bus.data1 = w; bus.req1 = 1'b1; end
    else    begin bus.data0 = w; bus.req0 = 1'b1; end
    sb.push_back(e);
    wait_busy();
    lat = 0;
    while (!bus.done && lat < 60) begin tick(); lat++; end
    chk("done_latency", lat, WIDTH);
    if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    tick();
    chk("idle_after_done", 32'(bus.busy), 32'd0);
    chk("count_hold", 32'(bus.count), 32'(e.cnt));
    chk("gnt_hold", 32'(bus.gnt_id), 32'(id));
  endtask

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    chk("rst_ser_bit", 32'(bus.ser_bit), 32'd0);
    reset = 1'b1;
    tick();

    run_job(1'b0, 8'b10101010);
    run_job(1'b1, 8'b11010100);
    run_job(1'b0, 8'h00);
    run_job(1'b0, 8'hFF);

    // Abort a req1 job in its 4th shift cycle.
    bus.data1 = 8'b10101010;
    bus.req1 = 1'b1;
    wait_busy();
    tick(); tick(); tick();
    chk("pre_abort_gnt", 32'(bus.gnt_id), 32'd1);
    reset = 1'b0;
    bus.req1 = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_count", 32'(bus.count), 32'd0);
    chk("abort_gnt_id", 32'(bus.gnt_id), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_ser_bit", 32'(bus.ser_bit), 32'd0);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    run_job(1'b0, 8'b10101010);

    // Both requesters from reset: req0, req1, req0.
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    acc_q.delete();
    bus.data0 = 8'b10101010;
    bus.data1 = 8'b10101010;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    sb.push_back(mk_exp(1'b0, 8'b10101010));
    sb.push_back(mk_exp(1'b1, 8'b10101010));
    sb.push_back(mk_exp(1'b0, 8'b10101010));
    wait_done();
    bus.req0 = 1'b0;
    tick();
    bus.req0 = 1'b1;
    wait_done();
    bus.req1 = 1'b0;
    tick();
    wait_done();
    bus.req0 = 1'b0;
    tick(); tick();
    chk("tie_accepts", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("tie_spacing_1", acc_q[1] - acc_q[0], WIDTH + 2);
      chk("tie_spacing_2", acc_q[2] - acc_q[1], WIDTH + 2);
    end

    // req1 arrives mid-job with changing data; only the value at its accept counts.
    acc_q.delete();
    bus.data0 = 8'b10101010;
    bus.req0 = 1'b1;
    sb.push_back(mk_exp(1'b0, 8'b10101010));
    sb.push_back(mk_exp(1'b1, 8'b11010100));
    wait_busy();
    tick();
    bus.data1 = 8'h55;
    bus.req1 = 1'b1;
    tick(); tick();
    bus.data1 = 8'b11010100;
    wait_done();
    bus.req0 = 1'b0;
    tick();
    wait_done();
    bus.req1 = 1'b0;
    tick(); tick();
    chk("late_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) chk("late_spacing", acc_q[1] - acc_q[0], WIDTH + 2);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
